executs_md: RTL and testbench
=============================

EXECUTS_MD -- requirements
Module: executs_md

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width (legal range 8..64).
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, with asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin an operation, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2, the operation select: 00 multu, 01 mult, 10 divu, 11 div; sampled with start.
REQ-006 The block SHALL have port operand_a, input, WIDTH, the rs value (multiplicand or dividend); sampled with start.
REQ-007 The block SHALL have port operand_b, input, WIDTH, the rt value (multiplier or divisor); sampled with start.
REQ-008 The block SHALL have ports mthi and mtlo, input, 1 each, requests to write wdata into HI or LO.
REQ-009 The block SHALL have port wdata, input, WIDTH, the data for mthi and mtlo.
REQ-010 The block SHALL have ports hi and lo, output, WIDTH each, which are the architectural HI/LO registers driven directly from flops.
REQ-011 The block SHALL have port busy, output, 1, high while an operation is iterating.
REQ-012 The block SHALL have port done, output, 1, a one-cycle pulse when HI/LO take a result.
REQ-013 The block SHALL have port div_by_zero, output, 1, a one-cycle pulse coincident with done for a divide with operand_b==0.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and FINISH.
REQ-015 IDLE SHALL go to RUN when start=1: latch op and the operands, load the iteration counter with WIDTH, and set busy=1 at that edge.
REQ-016 RUN SHALL perform one iteration per cycle.
REQ-017 Multiply SHALL use unsigned shift-add over the operand magnitudes, one multiplier bit per cycle.
REQ-018 Divide SHALL use restoring shift-subtract over the magnitudes, one quotient bit per cycle.
REQ-019 RUN SHALL last exactly WIDTH cycles, then go to FINISH.
REQ-020 FINISH SHALL apply the sign fix-up, write hi/lo, drive done=1 and busy=0 for one cycle, then return to IDLE.
REQ-021 Latency SHALL be fixed: with start sampled at edge E0, hi/lo change and done rises at edge E0+WIDTH+1; busy is high from E0 to E0+WIDTH+1.
REQ-022 Multiply results SHALL be the full 2*WIDTH-bit product, with HI the upper half and LO the lower half.
REQ-023 For mult, the product SHALL be negated when the operand signs differ.
REQ-024 Divide results SHALL be LO=quotient and HI=remainder.
REQ-025 For div, the quotient SHALL be truncated toward zero, and the remainder sign SHALL equal the dividend sign (zero remainder stays zero).
REQ-026 div of the most-negative value by -1 SHALL give LO=most-negative value and HI=0, with no error flag.
REQ-027 A divide with divisor 0 SHALL keep the same latency, leave hi/lo unchanged, and pulse div_by_zero with done.
REQ-028 start while busy (RUN or FINISH) SHALL be ignored; it is not queued.
REQ-029 mthi/mtlo in IDLE SHALL write wdata to hi/lo at the next edge; mthi and mtlo together SHALL write both.
REQ-030 mthi/mtlo while busy SHALL be ignored.
REQ-031 start and mthi/mtlo together in IDLE: start SHALL win, and the move SHALL be discarded.
REQ-032 Operand inputs changing after the start edge SHALL NOT affect the result.

Reset
REQ-033 reset=0 SHALL asynchronously force state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, and clear the counter and internal registers.
REQ-034 Reset mid-operation SHALL abort it, with no done pulse and no hi/lo write after release.
REQ-035 After reset deasserts, the first start SHALL be accepted at the first rising edge with reset=1.

Verification (WIDTH=32)
REQ-036 The bench SHALL check multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done at edge E0+33, busy high for exactly 33 cycles.
REQ-037 The bench SHALL check mult 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-038 The bench SHALL check div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 The bench SHALL check mthi 0x12345678 then divu 7 / 0 -> done and div_by_zero pulse together at E0+33, hi stays 0x12345678, lo stays 0.
REQ-040 The bench SHALL check multu 3 x 4 with reset driven low mid-RUN at cycle 10 -> hi=lo=0 immediately, busy=0, and no done within 40 cycles after release.
REQ-041 The bench SHALL check start plus mtlo (wdata=0xAAAA) while busy -> both ignored, the original result is written, and lo does not become 0xAAAA.

Source files
------------

// File: rtl/executs_md.sv
// rtl/executs_md.sv - iterative HI/LO multiply/divide unit (multu, mult, divu, div, mthi, mtlo)
module executs_md #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Operation context captured at the start edge
    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_main;   // negate product or quotient
    logic             neg_rem;    // negate remainder (dividend was negative)
    logic             dz_flag;    // divide with zero divisor: result is discarded

    // Iteration registers: acc is the product high half / partial remainder,
    // shreg holds the multiplier (shifting out) or dividend/quotient,
    // mag_b is the multiplicand or divisor magnitude.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] mag_b;

    // Control strobes decoded from state
    logic             load;
    logic             step;
    logic             finish;
    logic             move_hi;
    logic             move_lo;

    // Operand magnitudes and signs at the start edge
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;

    // Per-iteration arithmetic
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;

    // Final results after sign fix-up
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: RUN lasts exactly WIDTH cycles, FINISH one cycle
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_RUN;
            S_RUN:    if (count == CW'(1)) state_nx = S_FINISH;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Output/strobe decode: start beats a simultaneous move, moves ignored when busy
    always_comb begin
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        move_hi = 1'b0;
        move_lo = 1'b0;
        case (state)
            S_IDLE: begin
                load    = start;
                move_hi = !start && mthi;
                move_lo = !start && mtlo;
            end
            S_RUN:    step   = 1'b1;
            S_FINISH: finish = 1'b1;
            default: ;
        endcase
    end

    // Operand magnitudes: only the signed ops (op[0]=1) treat the MSB as a sign
    always_comb begin
        a_neg    = op[0] && operand_a[WIDTH-1];
        b_neg    = op[0] && operand_b[WIDTH-1];
        mag_a_in = a_neg ? -operand_a : operand_a;
        mag_b_in = b_neg ? -operand_b : operand_b;
    end

    // One shift-add or restoring shift-subtract step
    always_comb begin
        mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
        div_shift = {acc, shreg[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mag_b};
        // When div_ge holds the true difference is below mag_b, so WIDTH bits suffice
        div_sub   = div_shift[WIDTH-1:0] - mag_b;
    end

    // Sign fix-up of the unsigned magnitude results
    always_comb begin
        product  = {acc, shreg};
        prod_fix = neg_main ? -product : product;
        quot_fix = neg_main ? -shreg : shreg;
        rem_fix  = neg_rem ? -acc : acc;
    end

    // Iteration datapath and latched operation context
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            dz_flag  <= 1'b0;
            acc      <= '0;
            shreg    <= '0;
            mag_b    <= '0;
        end else if (load) begin
            count    <= CW'(WIDTH);
            is_div   <= op[1];
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            dz_flag  <= op[1] && (operand_b == '0);
            acc      <= '0;
            shreg    <= mag_a_in;
            mag_b    <= mag_b_in;
        end else if (step) begin
            count <= count - CW'(1);
            if (is_div) begin
                acc   <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                shreg <= {shreg[WIDTH-2:0], div_ge};
            end else begin
                acc   <= mul_sum[WIDTH:1];
                shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
            end
        end
    end

    // Architectural HI/LO: written by a finished operation or by a move in IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (finish) begin
            if (!is_div) begin
                hi <= prod_fix[2*WIDTH-1:WIDTH];
                lo <= prod_fix[WIDTH-1:0];
            end else if (!dz_flag) begin
                hi <= rem_fix;
                lo <= quot_fix;
            end
        end else begin
            if (move_hi) hi <= wdata;
            if (move_lo) lo <= wdata;
        end
    end

    // Status flags: busy spans start edge to result edge, done/div_by_zero pulse once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            if (load) begin
                busy <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
            end
            done        <= finish;
            div_by_zero <= finish && dz_flag;
        end
    end

endmodule

// File: tb/tb_executs_md.sv
// tb/tb_executs_md.sv - self-checking bench for executs_md
module tb_executs_md;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int n_vec = 0;
    int n_bad = 0;

    executs_md #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, SV division truncates toward zero
    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] hi_in, input logic [W-1:0] lo_in,
                                  output logic [W-1:0] ehi, output logic [W-1:0] elo,
                                  output logic edz);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        edz = 1'b0;
        ehi = hi_in;
        elo = lo_in;
        case (o)
            2'd0: begin
                p = {32'd0, a} * {32'd0, b};
                ehi = p[63:32];
                elo = p[31:0];
            end
            2'd1: begin
                p = sa * sb;
                ehi = p[63:32];
                elo = p[31:0];
            end
            2'd2: begin
                if (b == 0) edz = 1'b1;
                else begin
                    elo = a / b;
                    ehi = a % b;
                end
            end
            default: begin
                if (b == 0) edz = 1'b1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    elo = q[31:0];
                    ehi = r[31:0];
                end
            end
        endcase
    endfunction

    // Issue one op, scramble operands after the start edge, wait (bounded) for done
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic with_mtlo,
                          output int lat, output int bcnt, output logic dz_seen);
        @(negedge clock);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        mtlo      = with_mtlo;
        wdata     = 32'h0000_5555;
        @(posedge clock);
        #1;
        start     = 1'b0;
        mtlo      = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        op        = 2'($urandom);
        @(negedge clock);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        dz_seen = div_by_zero;
    endtask

    vec_t         vecs[12];
    int           lat;
    int           bcnt;
    logic         dzs;
    logic         seen_done;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    logic         e_dz;
    logic [1:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{2'd0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C};
        vecs[5]  = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[6]  = '{2'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[8]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[9]  = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[10] = '{2'd3, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0001};
        vecs[11] = '{2'd3, 32'hFFFF_FFF8, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFE};

        // Reset state
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_hi", 64'(hi), 64'h0);
        check("reset_lo", 64'(lo), 64'h0);
        check("reset_flags", {61'd0, busy, done, div_by_zero}, 64'h0);
        reset = 1'b1;

        // mthi then divu 7/0: same latency, hi/lo kept, dz pulses with done
        @(negedge clock);
        wdata = 32'h1234_5678;
        mthi  = 1'b1;
        @(posedge clock);
        #1 mthi = 1'b0;
        @(negedge clock);
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        run_op(2'd2, 32'd7, 32'd0, 1'b0, lat, bcnt, dzs);
        check("dz_latency", 64'(lat), 64'd33);
        check("dz_done_pulse", {62'd0, done, dzs}, 64'h3);
        check("dz_hi", 64'(hi), 64'h1234_5678);
        check("dz_lo", 64'(lo), 64'h0);
        @(negedge clock);
        check("dz_one_cycle", {62'd0, done, div_by_zero}, 64'h0);

        // mthi and mtlo together write both
        wdata = 32'h0BAD_F00D;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        @(posedge clock);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        @(negedge clock);
        check("mv_both", {hi, lo}, {32'h0BAD_F00D, 32'h0BAD_F00D});

        // start with mtlo in IDLE: start wins
        run_op(2'd0, 32'd3, 32'd4, 1'b1, lat, bcnt, dzs);
        check("start_wins", {hi, lo}, {32'h0, 32'h0000_000C});

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bcnt, dzs);
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].ehi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].elo));
            check($sformatf("vec%0d_timing", i), {lat, bcnt}, {32'd33, 32'd33});
            check($sformatf("vec%0d_flags", i), {61'd0, busy, done, dzs}, 64'h2);
        end

        // start and mtlo while busy are both ignored, start is not queued
        @(negedge clock);
        op = 2'd0; operand_a = 32'd3; operand_b = 32'd4; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(negedge clock);
        op = 2'd1; operand_a = 32'h55; operand_b = 32'h66; start = 1'b1;
        mtlo = 1'b1; wdata = 32'h0000_AAAA;
        @(negedge clock);
        start = 1'b0;
        mtlo  = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("busy_ign_done", 64'(done), 64'h1);
        check("busy_ign_result", {hi, lo}, {32'h0, 32'h0000_000C});
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done || lo == 32'h0000_AAAA) seen_done = 1'b1;
        end
        check("busy_ign_no_queue", 64'(seen_done), 64'h0);

        // Reset mid-RUN aborts with no later done
        @(negedge clock);
        op = 2'd0; operand_a = 32'd3; operand_b = 32'd4; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst_hilo", {hi, lo}, 64'h0);
        check("midrst_flags", {61'd0, busy, done, div_by_zero}, 64'h0);
        @(negedge clock);
        reset = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) seen_done = 1'b1;
        end
        check("midrst_no_done", 64'(seen_done), 64'h0);
        check("midrst_hilo_after", {hi, lo}, 64'h0);

        // Randomized ops against the reference model
        m_hi = '0;
        m_lo = '0;
        for (int i = 0; i < 150; i++) begin
            r_op = 2'($urandom);
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = '0;
                1: r_b = 32'($urandom_range(0, 15));
                2: r_a = 32'($urandom_range(0, 300));
                3: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            model(r_op, r_a, r_b, m_hi, m_lo, e_hi, e_lo, e_dz);
            run_op(r_op, r_a, r_b, 1'b0, lat, bcnt, dzs);
            check($sformatf("rnd%0d_op%0d_%h_%h", i, r_op, r_a, r_b),
                  {hi, lo}, {e_hi, e_lo});
            check($sformatf("rnd%0d_ctl", i), {29'd0, lat, done, dzs, busy},
                  {29'd0, 32'd33, 1'b1, e_dz, 1'b0});
            m_hi = e_hi;
            m_lo = e_lo;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
